mips_cpu_muldiv_seq: RTL and testbench
======================================

// Module: mips_cpu_muldiv_seq
// PURPOSE
//  Parametrised, multi-cycle successor of the CPU's single-cycle HI/LO mult/div unit.
//  Radix-2 iterative shift-add multiplier and restoring divider share one datapath and own HI/LO.
//  Sits beside the ALU in execute. The pipeline stalls on busy and may flush an operation with cancel.
// PARAMETERS
//  WIDTH  32  operand and HI/LO width in bits; must be >= 4
// PORTS
//  clk      in   1      clock; all state changes on the rising edge
//  reset_n  in   1      asynchronous, active-low reset
//  a        in   WIDTH  rs operand: multiplicand/dividend, or MTHI/MTLO data
//  b        in   WIDTH  rt operand: multiplier/divisor
//  op       in   3      000 DIVU, 001 MULTU, 010 DIV, 011 MULT, 100 MTHI, 101 MTLO, 110/111 no-op
//  write    in   1      request strobe; sampled only when busy=0
//  cancel   in   1      exception flush; aborts the operation in flight
//  busy     out  1      mult/div in progress; HI/LO reads must stall while high
//  done     out  1      one-cycle pulse in the cycle after HI/LO take a mult/div result
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
// BEHAVIOUR
//  Reset: reset_n=0 clears hi, lo, busy, done, counter and internal regs immediately. State -> IDLE.
//    Reset mid-operation discards the operation. No done is produced.
//  States: IDLE -> CALC -> FIX -> IDLE.
//  IDLE, write=1, cancel=0 (accept edge E0):
//    op 100/101: hi (or lo) <= a at E0; the other register is unchanged; stay IDLE; busy stays 0.
//    op 110/111: no state change.
//    op 000-011: latch operands (signed ops: latch magnitudes and signs), counter <= WIDTH,
//      go to CALC; busy=1 from E0.
//  CALC: one bit per edge, E1..E(WIDTH). Counter decrements and reaches 0 at E(WIDTH), then -> FIX.
//  FIX, edge E(WIDTH+1):
//    sign correction; write hi/lo; busy <= 0; done <= 1 for exactly one cycle; -> IDLE.
//    Latency: result visible WIDTH+1 edges after the accept edge (33 for WIDTH=32).
//  Results:
//    MULT/MULTU: {hi,lo} = full 2*WIDTH product; MULT is two's-complement signed.
//    DIV/DIVU: lo = quotient, hi = remainder.
//      Signed: quotient truncates toward zero. Quotient negative iff sign(a)^sign(b).
//      Remainder takes the sign of a (or 0).
//    Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and is held exactly in WIDTH unsigned bits.
//    DIV -2^(WIDTH-1) / -1: lo = -2^(WIDTH-1) (wraps), hi = 0.
//    Divide by zero (DIV or DIVU, any a): lo = all ones, hi = a.
//  While busy=1:
//    write is ignored entirely, including MTHI/MTLO; hi/lo keep their old values until FIX.
//  cancel=1 while busy=1 (CALC or FIX): next edge -> IDLE, busy=0, hi/lo unchanged, no done.
//  cancel=1 with write=1 in IDLE: cancel wins; nothing is accepted.
//  A new write is accepted in the same cycle done=1 (busy is already 0), so back-to-back ops are allowed.
//  hi, lo, busy, done are all registered outputs.
// TESTING (WIDTH=32)
//  T1 MULTU a=FFFFFFFF b=FFFFFFFF -> busy 33 cycles, then hi=FFFFFFFE lo=00000001, done pulses once.
//  T2 MULT a=FFFFFFFD(-3) b=7 -> hi=FFFFFFFF lo=FFFFFFEB.
//     MULT 80000000*80000000 -> hi=40000000 lo=0.
//  T3 DIV a=-7 b=2 -> lo=FFFFFFFD(-3) hi=FFFFFFFF(-1).
//     DIVU a=7 b=2 -> lo=3 hi=1.
//     DIV 80000000/FFFFFFFF -> lo=80000000 hi=0.
//  T4 DIVU and DIV with b=0, a=12345678 -> lo=FFFFFFFF hi=12345678.
//  T5 MTHI a=AAAA5555 issued while busy -> ignored.
//     MTHI in IDLE -> hi=AAAA5555 next edge, lo unchanged, busy stays 0.
//  T6 cancel at cycle 10 of a MULT -> busy=0 next edge, hi/lo retain prior values, done never pulses.
//     reset_n low mid-DIV -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mips_cpu_muldiv_seq_if.sv
// Request/result bundle between execute stage and the HI/LO mult/div unit.
// The pipeline side drives operands and strobes; the unit returns HI/LO and status.
interface mips_cpu_muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             write;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output a, b, op, write, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  a, b, op, write, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_cpu_muldiv_seq.sv
// Multi-cycle HI/LO unit: radix-2 shift-add multiplier and restoring divider
// sharing one accumulator/shift datapath, with MTHI/MTLO writes.
module mips_cpu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mips_cpu_muldiv_seq_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] pq_q, pq_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             divz_q, divz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic             start;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    assign accept = (state_q == IDLE) && bus.write && !bus.cancel;
    assign start  = accept && !bus.op[2];
    assign sa     = bus.op[1] & bus.a[WIDTH-1];
    assign sb     = bus.op[1] & bus.b[WIDTH-1];
    assign mag_a  = sa ? -bus.a : bus.a;
    assign mag_b  = sb ? -bus.b : bus.b;

    // Multiply adds into the high half then shifts {acc,pq} right;
    // divide shifts {acc,pq} left and trial-subtracts the divisor.
    assign sum    = {1'b0, acc_q} + (pq_q[0] ? {1'b0, m_q} : '0);
    assign sh     = {acc_q, pq_q[WIDTH-1]};
    assign diff   = sh - {1'b0, m_q};
    assign prod   = {acc_q, pq_q};
    assign prod_s = negq_q ? -prod : prod;
    assign quo    = negq_q ? -pq_q : pq_q;
    assign rem    = negr_q ? -acc_q : acc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            pq_q    <= '0;
            m_q     <= '0;
            a_q     <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            divz_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
            pq_q    <= pq_d;
            m_q     <= m_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            divz_q  <= divz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = CALC;
            CALC: begin
                if (bus.cancel) state_d = IDLE;
                else if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        acc_d  = acc_q;
        pq_d   = pq_q;
        m_d    = m_q;
        a_d    = a_q;
        cnt_d  = cnt_q;
        div_d  = div_q;
        negq_d = negq_q;
        negr_d = negr_q;
        divz_d = divz_q;
        busy_d = busy_q;
        done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && bus.op == 3'b100) hi_d = bus.a;
                if (accept && bus.op == 3'b101) lo_d = bus.a;
                if (start) begin
                    acc_d  = '0;
                    m_d    = bus.op[0] ? mag_a : mag_b;
                    pq_d   = bus.op[0] ? mag_b : mag_a;
                    a_d    = bus.a;
                    cnt_d  = CW'(WIDTH);
                    div_d  = !bus.op[0];
                    negq_d = sa ^ sb;
                    negr_d = sa;
                    divz_d = !bus.op[0] && (bus.b == '0);
                    busy_d = 1'b1;
                end
            end
            CALC: begin
                if (bus.cancel) begin
                    busy_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (div_q) begin
                        acc_d = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
                        pq_d  = {pq_q[WIDTH-2:0], !diff[WIDTH]};
                    end else begin
                        acc_d = sum[WIDTH:1];
                        pq_d  = {sum[0], pq_q[WIDTH-1:1]};
                    end
                end
            end
            FIX: begin
                busy_d = 1'b0;
                if (!bus.cancel) begin
                    done_d = 1'b1;
                    if (!div_q) begin
                        hi_d = prod_s[2*WIDTH-1:WIDTH];
                        lo_d = prod_s[WIDTH-1:0];
                    end else if (divz_q) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            default: busy_d = 1'b0;
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// Directed bench for the sequential HI/LO mult/div unit at WIDTH=32.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mips_cpu_muldiv_seq;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mips_cpu_muldiv_seq_if #(.WIDTH(32)) bus ();

    mips_cpu_muldiv_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Called on a falling edge; returns on the falling edge after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        bus.a = '0; bus.b = '0; bus.op = 3'b110;
        bus.write = 1'b0; bus.cancel = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want %h", bus.hi, 32'h0); end
        checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want %h", bus.lo, 32'h0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    endtask

    task automatic test_multu;
        int n;
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(n);
        checks++; if (n != 33) begin errors++; $display("FAIL multu_busy_cycles got %0d want 33", n); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL multu_done got %b want 1", bus.done); end
        checks++; if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want %h", bus.hi, 32'hFFFFFFFE); end
        checks++; if (bus.lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want %h", bus.lo, 32'h1); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b want 0", bus.done); end
    endtask

    task automatic test_mult;
        int n;
        issue(3'b011, 32'hFFFFFFFD, 32'h7);
        wait_done(n);
        checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_neg_hi got %h want %h", bus.hi, 32'hFFFFFFFF); end
        checks++; if (bus.lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_neg_lo got %h want %h", bus.lo, 32'hFFFFFFEB); end
        @(negedge clk);
        issue(3'b011, 32'h80000000, 32'h80000000);
        wait_done(n);
        checks++; if (bus.hi !== 32'h40000000) begin errors++; $display("FAIL mult_min_hi got %h want %h", bus.hi, 32'h40000000); end
        checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL mult_min_lo got %h want %h", bus.lo, 32'h0); end
        @(negedge clk);
    endtask

    task automatic test_div;
        int n;
        issue(3'b010, 32'hFFFFFFF9, 32'h2);
        wait_done(n);
        checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo got %h want %h", bus.lo, 32'hFFFFFFFD); end
        checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi got %h want %h", bus.hi, 32'hFFFFFFFF); end
        @(negedge clk);
        issue(3'b000, 32'h7, 32'h2);
        wait_done(n);
        checks++; if (bus.lo !== 32'h3) begin errors++; $display("FAIL divu_lo got %h want %h", bus.lo, 32'h3); end
        checks++; if (bus.hi !== 32'h1) begin errors++; $display("FAIL divu_hi got %h want %h", bus.hi, 32'h1); end
        @(negedge clk);
        issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
        wait_done(n);
        checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h want %h", bus.lo, 32'h80000000); end
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h want %h", bus.hi, 32'h0); end
        @(negedge clk);
    endtask

    task automatic test_divzero;
        int n;
        issue(3'b000, 32'h12345678, 32'h0);
        wait_done(n);
        checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_z_lo got %h want %h", bus.lo, 32'hFFFFFFFF); end
        checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("FAIL divu_z_hi got %h want %h", bus.hi, 32'h12345678); end
        @(negedge clk);
        issue(3'b010, 32'h12345678, 32'h0);
        wait_done(n);
        checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_z_lo got %h want %h", bus.lo, 32'hFFFFFFFF); end
        checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("FAIL div_z_hi got %h want %h", bus.hi, 32'h12345678); end
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo;
        int n;
        issue(3'b001, 32'h2, 32'h3);
        bus.op = 3'b100; bus.a = 32'hAAAA5555; bus.write = 1'b1;
        repeat (2) @(negedge clk);
        bus.write = 1'b0;
        wait_done(n);
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL mthi_busy_hi got %h want %h", bus.hi, 32'h0); end
        checks++; if (bus.lo !== 32'h6) begin errors++; $display("FAIL mthi_busy_lo got %h want %h", bus.lo, 32'h6); end
        @(negedge clk);
        issue(3'b100, 32'hAAAA5555, 32'h0);
        checks++; if (bus.hi !== 32'hAAAA5555) begin errors++; $display("FAIL mthi_hi got %h want %h", bus.hi, 32'hAAAA5555); end
        checks++; if (bus.lo !== 32'h6) begin errors++; $display("FAIL mthi_lo got %h want %h", bus.lo, 32'h6); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b want 0", bus.busy); end
        issue(3'b101, 32'h13579BDF, 32'h0);
        checks++; if (bus.lo !== 32'h13579BDF) begin errors++; $display("FAIL mtlo_lo got %h want %h", bus.lo, 32'h13579BDF); end
        checks++; if (bus.hi !== 32'hAAAA5555) begin errors++; $display("FAIL mtlo_hi got %h want %h", bus.hi, 32'hAAAA5555); end
        bus.cancel = 1'b1;
        issue(3'b100, 32'h0, 32'h0);
        bus.cancel = 1'b0;
        checks++; if (bus.hi !== 32'hAAAA5555) begin errors++; $display("FAIL cancel_write_hi got %h want %h", bus.hi, 32'hAAAA5555); end
        issue(3'b110, 32'h0, 32'h0);
        checks++; if (bus.busy !== 1'b0 || bus.lo !== 32'h13579BDF) begin errors++; $display("FAIL nop_state got busy=%b lo=%h want busy=0 lo=%h", bus.busy, bus.lo, 32'h13579BDF); end
    endtask

    task automatic test_cancel;
        logic seen;
        issue(3'b100, 32'h11111111, 32'h0);
        issue(3'b101, 32'h22222222, 32'h0);
        issue(3'b011, 32'h5, 32'h6);
        repeat (9) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b want 0", bus.busy); end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL cancel_done got %b want 0", seen); end
        checks++; if (bus.hi !== 32'h11111111) begin errors++; $display("FAIL cancel_hi got %h want %h", bus.hi, 32'h11111111); end
        checks++; if (bus.lo !== 32'h22222222) begin errors++; $display("FAIL cancel_lo got %h want %h", bus.lo, 32'h22222222); end
    endtask

    task automatic test_back_to_back;
        int n;
        issue(3'b000, 32'd100, 32'd7);
        wait_done(n);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", bus.done); end
        issue(3'b001, 32'h10000, 32'h10000);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b want 1", bus.busy); end
        checks++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin errors++; $display("FAIL b2b_first got hi=%h lo=%h want hi=2 lo=e", bus.hi, bus.lo); end
        wait_done(n);
        checks++; if (n != 33) begin errors++; $display("FAIL b2b_cycles got %0d want 33", n); end
        checks++; if (bus.hi !== 32'h1 || bus.lo !== 32'h0) begin errors++; $display("FAIL b2b_second got hi=%h lo=%h want hi=1 lo=0", bus.hi, bus.lo); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        issue(3'b010, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got busy=%b done=%b want 0 0", bus.busy, bus.done); end
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL rst_mid_hilo got hi=%h lo=%h want 0 0", bus.hi, bus.lo); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL rst_mid_after got hi=%h lo=%h want 0 0", bus.hi, bus.lo); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_divzero();
        test_mthi_mtlo();
        test_cancel();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
